pcap_dma_feeder: RTL
====================

// Module: pcap_dma_feeder
// PURPOSE
//   Consumer end of the position-capture data stream. Accepts 32-bit words from pcap_core (pcap_dat/valid,
//   pcap_done, pcap_actv), buffers them in a FIFO and hands them to the DMA engine as length-tagged bursts.
//   Drives the dma_full back-pressure flag that pcap_core samples. Flushes a partial burst at end of capture.
// PARAMETERS
//   FIFO_DEPTH   1024  FIFO depth in 32-bit words; power of 2
//   BLOCK_WORDS  256   maximum burst length in words; 1..FIFO_DEPTH
//   FULL_MARGIN  16    dma_full_o asserts when level >= FIFO_DEPTH-FULL_MARGIN
//   AW           10    log2(FIFO_DEPTH); level is AW+1 bits wide
// PORTS
//   clk_i             in   1     system clock; single clock domain
//   reset_i           in   1     asynchronous, active-high reset
//   pcap_dat_i        in   32    capture data word
//   pcap_dat_valid_i  in   1     write strobe for pcap_dat_i, one word per cycle
//   pcap_done_i       in   1     1-cycle pulse: capture finished, flush pending data
//   pcap_actv_i       in   1     capture active level; rising edge starts a new capture
//   dma_full_o        out  1     back-pressure to pcap_core dma_full_i
//   dma_req_o         out  1     burst request; held until dma_ack_i
//   dma_ack_i         in   1     DMA accepts request; 1-cycle pulse
//   dma_len_o         out  16    burst length in words; stable while dma_req_o high and during burst
//   dma_dat_o         out  32    burst data word
//   dma_dat_valid_o   out  1     dma_dat_o valid
//   dma_dat_ready_i   in   1     DMA sink accepts word when valid&ready
//   dma_last_o        out  1     final beat of burst; qualified by dma_dat_valid_o
//   done_o            out  1     1-cycle pulse: capture done and FIFO fully drained
//   overflow_o        out  1     sticky: a word was dropped because FIFO was full
//   fifo_level_o      out  AW+1  current FIFO occupancy
// BEHAVIOUR
//   Reset: every output 0, FIFO empty, FSM IDLE, done_pending=0, overflow=0. Async assert; deassert sync to clk_i.
//   FIFO: write on pcap_dat_valid_i when level<FIFO_DEPTH; pop on dma_dat_valid_o&dma_dat_ready_i.
//   - Write+pop in same cycle: level unchanged, both succeed (also when full). Pointers wrap mod FIFO_DEPTH.
//   - Write when full and no pop: word dropped, overflow_o<=1 next cycle; level stays FIFO_DEPTH.
//   - fifo_level_o and dma_full_o registered: reflect writes/pops of cycle N at N+1.
//   done_pending set by pcap_done_i; overflow_o and done_pending cleared on pcap_actv_i rising edge
//   (edge wins over a same-cycle pcap_done_i). FIFO contents never flushed by actv edge.
//   FSM:
//   - IDLE: if level>=BLOCK_WORDS, or done_pending and level>0 -> REQ; latch dma_len_o=min(level,BLOCK_WORDS).
//     Else if done_pending and level==0 -> pulse done_o for 1 cycle, clear done_pending, stay IDLE.
//   - REQ: dma_req_o=1; on dma_ack_i -> XFER, remaining=dma_len_o. dma_req_o drops cycle after ack.
//   - XFER: dma_dat_valid_o=1 whenever FIFO non-empty (show-ahead; data is head of FIFO).
//     Each accepted beat decrements remaining; dma_last_o=1 when remaining==1. After last beat -> IDLE.
//     valid/data held stable while ready=0; no data beats outside XFER.
//   Burst latency: REQ entered 1 cycle after level condition is true; first beat offered 1 cycle after ack.
//   done_o fires only in IDLE, so always after the last beat of the final burst (>=1 cycle later).
//   Reset mid-burst: burst aborted, no dma_last_o issued, all state cleared immediately.
// TESTING
//   1. 256 consecutive words 0..255, ack 2 cycles after req, ready=1 -> req len=256; beats 0..255 in order; last on beat 256; level 0.
//   2. 100 words then done pulse -> one burst len=100, last on beat 100; done_o 1-cycle pulse after burst; no further req.
//   3. 600 words, ready toggling 1/0 -> bursts 256,256, then done -> 88; every word once, in order, none lost.
//   4. 1025 writes, no ack -> dma_full_o=1 from level 1008; 1025th dropped, overflow_o=1, level 1024; actv rise clears overflow.
//   5. done with empty FIFO -> done_o pulse next cycle, dma_req_o stays 0; write+pop at full keeps level 1024.
//   6. reset_i asserted mid-XFER (async, between edges) -> all outputs 0 before next edge; level 0; FSM IDLE.

Source files
------------

// File: rtl/pcap_dma_feeder_if.sv
// Signal bundle between pcap_core, the DMA feeder and the DMA engine.
// slave = the feeder itself; master = the surrounding capture core and DMA engine.
interface pcap_dma_feeder_if #(
    parameter int AW = 10
);
    logic [31:0] pcap_dat_i;
    logic        pcap_dat_valid_i;
    logic        pcap_done_i;
    logic        pcap_actv_i;
    logic        dma_full_o;
    logic        dma_req_o;
    logic        dma_ack_i;
    logic [15:0] dma_len_o;
    logic [31:0] dma_dat_o;
    logic        dma_dat_valid_o;
    logic        dma_dat_ready_i;
    logic        dma_last_o;
    logic        done_o;
    logic        overflow_o;
    logic [AW:0] fifo_level_o;

    modport slave (
        input  pcap_dat_i, pcap_dat_valid_i, pcap_done_i, pcap_actv_i,
        input  dma_ack_i, dma_dat_ready_i,
        output dma_full_o, dma_req_o, dma_len_o, dma_dat_o, dma_dat_valid_o,
        output dma_last_o, done_o, overflow_o, fifo_level_o
    );

    modport master (
        output pcap_dat_i, pcap_dat_valid_i, pcap_done_i, pcap_actv_i,
        output dma_ack_i, dma_dat_ready_i,
        input  dma_full_o, dma_req_o, dma_len_o, dma_dat_o, dma_dat_valid_o,
        input  dma_last_o, done_o, overflow_o, fifo_level_o
    );
endinterface

// File: rtl/pcap_dma_feeder.sv
// Buffers position-capture words in a FIFO and hands them to the DMA engine as
// length-tagged bursts, flushing the partial tail when the capture finishes.
module pcap_dma_feeder #(
    parameter int FIFO_DEPTH  = 1024,
    parameter int BLOCK_WORDS = 256,
    parameter int FULL_MARGIN = 16,
    parameter int AW          = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    pcap_dma_feeder_if.slave bus
);
    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_TH   = (AW+1)'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [AW:0]   BLOCK_L   = (AW+1)'(BLOCK_WORDS);
    localparam logic [AW:0]   LEVEL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t        state_reg;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [31:0]   head_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          full_reg;
    logic          overflow_reg;
    logic          done_pending_reg;
    logic          actv_reg;
    logic          req_reg;
    logic          done_reg;
    logic [15:0]   len_reg;
    logic [15:0]   remaining_reg;

    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   level_next;
    logic [15:0]   burst_len;
    logic          fifo_full;
    logic          dat_valid;
    logic          pop;
    logic          push;
    logic          drop;
    logic          actv_rise;
    logic          done_now;
    logic          start_burst;
    logic          fire_done;

    assign fifo_full   = (level_reg == DEPTH_L);
    assign dat_valid   = (state_reg == XFER) && (level_reg != '0);
    assign pop         = dat_valid && bus.dma_dat_ready_i;
    // A pop frees a slot in the same cycle, so a write at full still lands.
    assign push        = bus.pcap_dat_valid_i && (!fifo_full || pop);
    assign drop        = bus.pcap_dat_valid_i && fifo_full && !pop;
    assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    assign actv_rise   = bus.pcap_actv_i && !actv_reg;
    assign done_now    = (done_pending_reg || bus.pcap_done_i) && !actv_rise;
    assign start_burst = (state_reg == IDLE) &&
                         ((level_reg >= BLOCK_L) || (done_now && level_reg != '0));
    assign fire_done   = (state_reg == IDLE) && done_now && (level_reg == '0);
    assign burst_len   = (level_reg >= BLOCK_L) ? 16'(BLOCK_WORDS) : 16'(level_reg);

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + LEVEL_ONE;
        end else if (!push && pop) begin
            level_next = level_reg - LEVEL_ONE;
        end
    end

    // Registered show-ahead read; bypass covers a word written into the slot that becomes head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.pcap_dat_i;
        end
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= bus.pcap_dat_i;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            full_reg         <= 1'b0;
            overflow_reg     <= 1'b0;
            done_pending_reg <= 1'b0;
            actv_reg         <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            full_reg   <= (level_next >= FULL_TH);
            actv_reg   <= bus.pcap_actv_i;

            if (actv_rise) begin
                overflow_reg <= 1'b0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
            end

            if (actv_rise || fire_done) begin
                done_pending_reg <= 1'b0;
            end else if (bus.pcap_done_i) begin
                done_pending_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            req_reg       <= 1'b0;
            len_reg       <= '0;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= fire_done;
            case (state_reg)
                IDLE: begin
                    if (start_burst) begin
                        state_reg <= REQ;
                        req_reg   <= 1'b1;
                        len_reg   <= burst_len;
                    end
                end
                REQ: begin
                    if (bus.dma_ack_i) begin
                        state_reg     <= XFER;
                        req_reg       <= 1'b0;
                        remaining_reg <= len_reg;
                    end
                end
                XFER: begin
                    if (pop) begin
                        remaining_reg <= remaining_reg - 16'd1;
                        if (remaining_reg == 16'd1) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.dma_full_o      = full_reg;
    assign bus.dma_req_o       = req_reg;
    assign bus.dma_len_o       = len_reg;
    assign bus.dma_dat_o       = dat_valid ? head_reg : 32'd0;
    assign bus.dma_dat_valid_o = dat_valid;
    assign bus.dma_last_o      = dat_valid && (remaining_reg == 16'd1);
    assign bus.done_o          = done_reg;
    assign bus.overflow_o      = overflow_reg;
    assign bus.fifo_level_o    = level_reg;
endmodule
